core_mem_arbiter: RTL and testbench
===================================

# core_mem_arbiter

Round-robin arbiter that shares one synchronous data-memory bank between `CORES` Core instances. It terminates each core's `enable_M`/`addr_M`/`wr_data_M`/`rd_data_M`/`ready_M` port and serialises the accesses onto a single-port SRAM with a 1-cycle read latency. It sits between the Core array and the shared data memory and owns all memory sequencing. Each core stalls on `~ready_M` while its LD/ST waits.

## Interface
Parameters:
- `CORES`, default 4: number of requesting cores; must be at least 2.
- `REG_W`, default 8: data width; matches the Core register width.
- `ADDR_W`, default 10: memory address width; matches the Core `addr_M` width.
- `ID_W`, default 2: width of the grant index, equal to ceil(log2 `CORES`).

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: reset is asynchronous and active-high.
- `enable_M`, in, 2*`CORES`: per-core command, slice i is [2i+1:2i]. 2'b01 = LD, 2'b10 = ST, 2'b00 = idle, 2'b11 = illegal.
- `addr_M`, in, `ADDR_W`*`CORES`: per-core address.
- `wr_data_M`, in, `REG_W`*`CORES`: per-core store data.
- `rd_data_M`, out, `REG_W`*`CORES`: per-core load data.
- `ready_M`, out, `CORES`: per-core completion pulse.
- `mem_en`, out, 1: SRAM access strobe.
- `mem_we`, out, 1: SRAM write enable.
- `mem_addr`, out, `ADDR_W`: SRAM address.
- `mem_wdata`, out, `REG_W`: SRAM write data.
- `mem_rdata`, in, `REG_W`: SRAM read data, valid the cycle after `mem_en` with `mem_we`=0.
- `busy`, out, 1: high while the state is not IDLE.
- `grant_id`, out, `ID_W`: index of the core currently being served.
- `err_illegal`, out, 1: sticky flag, set by any 2'b11 command, cleared only by reset.

## Operation
- Core i is a requester when its `enable_M` slice is 01 or 10. A slice of 11 is not a request and sets `err_illegal`.
- Core contract: a requesting core holds `enable_M`, `addr_M` and `wr_data_M` stable until the cycle it sees `ready_M[i]`=1.
- FSM states are IDLE, ACCESS and RESP.
  - IDLE: if any requester exists, pick the first requester found searching upward from `last_grant`+1, with wrap-around modulo `CORES`. Register it into `grant_id` and go to ACCESS. With no requester, stay in IDLE.
  - ACCESS: `mem_en`=1, `mem_we`=(command of core `grant_id` == 10), `mem_addr`/`mem_wdata` = slices of core `grant_id`. Go to RESP unconditionally.
  - RESP: `ready_M[grant_id]`=1. Slice `grant_id` of `rd_data_M` = `mem_rdata` (combinational pass-through, also driven for ST). Set `last_grant` to `grant_id`, then go to IDLE.
- All `rd_data_M` slices other than the one in RESP are 0. `ready_M` is one-hot or all-zero at all times.
- No arbitration happens in RESP. The served core still shows its old command in that cycle, and it is not re-granted.
- If core `grant_id` drops its request during ACCESS (a contract violation), the transaction still completes and `ready_M` still pulses.
- `last_grant` resets to `CORES`-1, so core 0 wins the first contention.
- Outputs are registered decodes of state and `grant_id`, except the `mem_*` data and address fields and `rd_data_M`, which are combinational muxes.

## Timing
- Reset (asynchronous): state=IDLE, `grant_id`=0, `last_grant`=`CORES`-1, `err_illegal`=0. All outputs are 0: `ready_M`, `mem_en`, `mem_we`, `busy`, `rd_data_M`, `mem_addr`, `mem_wdata`.
- Reset asserted mid-ACCESS or mid-RESP aborts the transaction. No `ready_M` pulse is issued, and `mem_en` drops immediately.
- Latency: a request first visible at edge N (IDLE) gives ACCESS in cycle N+1 and the `ready_M` pulse in cycle N+2. An uncontended access therefore costs the core 2 stall cycles.
- Throughput: one access per 3 cycles. Back-to-back: RESP goes to IDLE, and IDLE arbitrates on the next cycle.
- Worst-case wait for core i with all cores requesting: `CORES`*3 cycles.
- `err_illegal` is set on the edge after the illegal command is sampled, in any state.

## Test plan
- Single LD: core 1 requests addr 0x05, SRAM[0x05]=0xA7 → `mem_en`=1/`mem_we`=0/`mem_addr`=0x05 in cycle 1. In cycle 2, `ready_M`=0010 and `rd_data_M` slice 1 = 0xA7. Other slices are 0.
- Single ST: core 2 issues 10, addr 0x3F, data 0x5C → ACCESS with `mem_we`=1 and `mem_wdata`=0x5C. `ready_M[2]` pulses in cycle 2. A later LD from core 0 at 0x3F returns 0x5C.
- Contention: all 4 cores issue LD in the same cycle after reset → grants in order 0, 1, 2, 3. The `ready_M` pulses land 3 cycles apart.
- Fairness: cores 0 and 3 hold requests continuously, re-requesting right after each ready → grants alternate 0, 3, 0, 3. Core 0 is never granted twice in a row.
- Illegal command: core 1 drives 11 for one cycle → `err_illegal`=1 and stays 1. No `mem_en` results from it. A normal LD still completes afterwards.
- Reset mid-op: assert `reset` during ACCESS of core 2 → `mem_en` and `busy` drop at once and no `ready_M` pulse occurs. After release, the pending request is re-served with core 0 priority restored.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter that serialises per-core LD/ST commands onto one
// single-port SRAM with a 1-cycle read latency (IDLE -> ACCESS -> RESP).
module core_mem_arbiter #(
    parameter int CORES  = 4,
    parameter int REG_W  = 8,
    parameter int ADDR_W = 10,
    parameter int ID_W   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*CORES-1:0]      enable_M,
    input  logic [ADDR_W*CORES-1:0] addr_M,
    input  logic [REG_W*CORES-1:0]  wr_data_M,
    output logic [REG_W*CORES-1:0]  rd_data_M,
    output logic [CORES-1:0]        ready_M,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [REG_W-1:0]        mem_wdata,
    input  logic [REG_W-1:0]        mem_rdata,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    err_illegal
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] CMD_LD  = 2'b01;
    localparam logic [1:0] CMD_ST  = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;

    state_t           r_state;
    logic [ID_W-1:0]  r_grant_id;
    logic [ID_W-1:0]  r_last_grant;
    logic             r_mem_en;
    logic             r_mem_we;
    logic             r_busy;
    logic             r_err_illegal;
    logic [CORES-1:0] r_ready;

    logic [CORES-1:0] w_req;
    logic             w_any_illegal;
    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic             w_winner_st;

    // Classify each core's command slice into request / illegal.
    always_comb begin
        w_req         = {CORES{1'b0}};
        w_any_illegal = 1'b0;
        for (int i = 0; i < CORES; i++) begin
            w_req[i]      = (enable_M[2*i +: 2] == CMD_LD) || (enable_M[2*i +: 2] == CMD_ST);
            w_any_illegal = w_any_illegal | (enable_M[2*i +: 2] == CMD_ILL);
        end
    end

    // Round-robin pick: scan downward so the nearest core after last_grant wins.
    always_comb begin
        w_found  = |w_req;
        w_winner = {ID_W{1'b0}};
        for (int k = CORES; k >= 1; k--) begin
            if (w_req[(int'(r_last_grant) + k) % CORES]) begin
                w_winner = ID_W'((int'(r_last_grant) + k) % CORES);
            end else begin
                w_winner = w_winner;
            end
        end
        w_winner_st = (enable_M[2*int'(w_winner) +: 2] == CMD_ST);
    end

    // Arbiter FSM with registered control outputs and sticky illegal flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant_id    <= {ID_W{1'b0}};
            r_last_grant  <= ID_W'(CORES - 1);
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_busy        <= 1'b0;
            r_err_illegal <= 1'b0;
            r_ready       <= {CORES{1'b0}};
        end else begin
            r_err_illegal <= r_err_illegal | w_any_illegal;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_ACCESS;
                        r_grant_id <= w_winner;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= w_winner_st;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    r_state  <= ST_RESP;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_ready  <= {{(CORES-1){1'b0}}, 1'b1} << r_grant_id;
                end
                ST_RESP: begin
                    // The served core still shows its command here; no arbitration.
                    r_state      <= ST_IDLE;
                    r_ready      <= {CORES{1'b0}};
                    r_busy       <= 1'b0;
                    r_last_grant <= r_grant_id;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_ready  <= {CORES{1'b0}};
                end
            endcase
        end
    end

    // Address/data muxes are gated so they read zero outside ACCESS.
    always_comb begin
        if (r_mem_en) begin
            mem_addr  = addr_M[ADDR_W*int'(r_grant_id) +: ADDR_W];
            mem_wdata = wr_data_M[REG_W*int'(r_grant_id) +: REG_W];
        end else begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {REG_W{1'b0}};
        end
    end

    // Load data passes straight through to the core currently in RESP.
    always_comb begin
        rd_data_M = {(REG_W*CORES){1'b0}};
        for (int i = 0; i < CORES; i++) begin
            rd_data_M[REG_W*i +: REG_W] = r_ready[i] ? mem_rdata : {REG_W{1'b0}};
        end
    end

    assign ready_M     = r_ready;
    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign busy        = r_busy;
    assign grant_id    = r_grant_id;
    assign err_illegal = r_err_illegal;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: directed core commands, a behavioural
// SRAM, and a negedge monitor checking every access and every ready pulse.
module tb_core_mem_arbiter;

    localparam int CORES  = 4;
    localparam int REG_W  = 8;
    localparam int ADDR_W = 10;
    localparam int ID_W   = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [2*CORES-1:0]      enable_M;
    logic [ADDR_W*CORES-1:0] addr_M;
    logic [REG_W*CORES-1:0]  wr_data_M;
    logic [REG_W*CORES-1:0]  rd_data_M;
    logic [CORES-1:0]        ready_M;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [REG_W-1:0]        mem_wdata;
    logic [REG_W-1:0]        mem_rdata;
    logic                    busy;
    logic [ID_W-1:0]         grant_id;
    logic                    err_illegal;

    core_mem_arbiter #(.CORES(CORES), .REG_W(REG_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .enable_M(enable_M), .addr_M(addr_M),
        .wr_data_M(wr_data_M), .rd_data_M(rd_data_M), .ready_M(ready_M),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {int core; logic we; logic [ADDR_W-1:0] addr; logic [REG_W-1:0] wdata;} acc_t;
    typedef struct {int core; logic [REG_W-1:0] data;} rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    int   rdy_cyc[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   loop_n;

    logic [1:0]        cmd  [CORES];
    logic [ADDR_W-1:0] adr  [CORES];
    logic [REG_W-1:0]  wd   [CORES];
    logic              hold [CORES];
    logic              rel  [CORES];

    logic [REG_W-1:0] sram [0:(1<<ADDR_W)-1];

    // Pack per-core command registers onto the DUT buses.
    always_comb begin
        for (int i = 0; i < CORES; i++) begin
            enable_M[2*i +: 2]            = cmd[i];
            addr_M[ADDR_W*i +: ADDR_W]    = adr[i];
            wr_data_M[REG_W*i +: REG_W]   = wd[i];
        end
    end

    // Write-first synchronous SRAM; known contents are loaded while reset is high.
    always @(posedge clk) begin
        if (reset) begin
            sram[10'h005] <= 8'hA7;
            sram[10'h010] <= 8'h21;
            sram[10'h011] <= 8'h32;
            sram[10'h012] <= 8'h43;
            sram[10'h013] <= 8'h54;
            sram[10'h020] <= 8'h66;
            sram[10'h023] <= 8'h99;
            sram[10'h040] <= 8'h77;
            sram[10'h041] <= 8'h88;
        end else if (mem_en) begin
            if (mem_we) begin
                sram[mem_addr] <= mem_wdata;
                mem_rdata      <= mem_wdata;
            end else begin
                mem_rdata      <= sram[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes memory or pulses ready.
    initial begin
        acc_t a;
        rsp_t r;
        logic [REG_W*CORES-1:0] exp_rd;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_en) begin
                    if (acc_q.size() == 0) begin
                        check("unexpected_mem_en", 64'(mem_en), 64'd0);
                    end else begin
                        a = acc_q.pop_front();
                        check("access", 64'({grant_id, mem_we, mem_addr, mem_wdata}),
                              64'({ID_W'(a.core), a.we, a.addr, a.wdata}));
                    end
                end
                if (ready_M != 4'b0000) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_ready", 64'(ready_M), 64'd0);
                    end else begin
                        r = rsp_q.pop_front();
                        exp_rd = {{(REG_W*(CORES-1)){1'b0}}, r.data} << (REG_W * r.core);
                        check("ready_onehot", 64'(ready_M), 64'(4'b0001 << r.core));
                        check("rd_data", 64'(rd_data_M), 64'(exp_rd));
                    end
                end else begin
                    check("rd_data_idle_zero", 64'(rd_data_M), 64'd0);
                end
            end
        end
    end

    // One clock: act #1 after the edge, releasing cores that saw ready last cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < CORES; i++) begin
            if (rel[i]) begin
                rel[i] = 1'b0;
                if (!hold[i]) cmd[i] = 2'b00;
            end
        end
        for (int i = 0; i < CORES; i++) begin
            if (ready_M[i]) rel[i] = 1'b1;
        end
        if (ready_M != 4'b0000) rdy_cyc.push_back(cyc);
    endtask

    task automatic issue(input int core, input logic [1:0] c, input logic [ADDR_W-1:0] a,
                         input logic [REG_W-1:0] d, input logic [REG_W-1:0] exp_rd);
        acc_t e;
        rsp_t r;
        cmd[core] = c;
        adr[core] = a;
        wd[core]  = d;
        e.core = core; e.we = (c == 2'b10); e.addr = a; e.wdata = d;
        acc_q.push_back(e);
        r.core = core; r.data = exp_rd;
        rsp_q.push_back(r);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((acc_q.size() != 0 || rsp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        check("drain_within_budget",
              64'(acc_q.size() == 0 && rsp_q.size() == 0 && !busy), 64'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < CORES; i++) begin
            cmd[i] = 2'b00; adr[i] = 10'h000; wd[i] = 8'h00; hold[i] = 1'b0; rel[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) step();
        check("rst_ready", 64'(ready_M), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_data", 64'(rd_data_M), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_err", 64'(err_illegal), 64'd0);
        reset = 1'b0;
        step();

        // Single LD from core 1
        issue(1, 2'b01, 10'h005, 8'h00, 8'hA7);
        step();
        check("ld_mem_en_c1", 64'(mem_en), 64'd1);
        check("ld_mem_we_c1", 64'(mem_we), 64'd0);
        check("ld_mem_addr_c1", 64'(mem_addr), 64'h005);
        check("ld_busy_c1", 64'(busy), 64'd1);
        check("ld_grant_c1", 64'(grant_id), 64'd1);
        step();
        check("ld_ready_c2", 64'(ready_M), 64'b0010);
        check("ld_rd_data_c2", 64'(rd_data_M), 64'h0000A700);
        check("ld_mem_en_off_c2", 64'(mem_en), 64'd0);
        wait_idle(20);

        // Single ST from core 2, then read back from core 0
        issue(2, 2'b10, 10'h03F, 8'h5C, 8'h5C);
        step();
        check("st_mem_we_c1", 64'(mem_we), 64'd1);
        check("st_mem_wdata_c1", 64'(mem_wdata), 64'h5C);
        step();
        check("st_ready_c2", 64'(ready_M), 64'b0100);
        wait_idle(20);
        issue(0, 2'b01, 10'h03F, 8'h00, 8'h5C);
        wait_idle(20);

        // Contention after reset: grants 0,1,2,3 spaced 3 cycles
        pulse_reset();
        rdy_cyc.delete();
        issue(0, 2'b01, 10'h010, 8'h00, 8'h21);
        issue(1, 2'b01, 10'h011, 8'h00, 8'h32);
        issue(2, 2'b01, 10'h012, 8'h00, 8'h43);
        issue(3, 2'b01, 10'h013, 8'h00, 8'h54);
        wait_idle(40);
        check("contention_pulse_count", 64'(rdy_cyc.size()), 64'd4);
        for (int k = 0; k < 3; k++) begin
            check("contention_gap", 64'(rdy_cyc[k+1] - rdy_cyc[k]), 64'd3);
        end

        // Fairness: cores 0 and 3 request continuously
        pulse_reset();
        hold[0] = 1'b1;
        hold[3] = 1'b1;
        issue(0, 2'b01, 10'h020, 8'h00, 8'h66);
        issue(3, 2'b01, 10'h023, 8'h00, 8'h99);
        issue(0, 2'b01, 10'h020, 8'h00, 8'h66);
        issue(3, 2'b01, 10'h023, 8'h00, 8'h99);
        loop_n = 0;
        while (rsp_q.size() != 0 && loop_n < 40) begin
            step();
            loop_n++;
        end
        hold[0] = 1'b0; hold[3] = 1'b0;
        cmd[0] = 2'b00; cmd[3] = 2'b00;
        rel[0] = 1'b0;  rel[3] = 1'b0;
        check("fairness_drained", 64'(rsp_q.size()), 64'd0);
        wait_idle(10);

        // Illegal command for one cycle
        check("err_clear_before", 64'(err_illegal), 64'd0);
        cmd[1] = 2'b11;
        step();
        cmd[1] = 2'b00;
        check("err_set", 64'(err_illegal), 64'd1);
        step();
        step();
        check("err_sticky", 64'(err_illegal), 64'd1);
        check("illegal_not_busy", 64'(busy), 64'd0);
        issue(1, 2'b01, 10'h005, 8'h00, 8'hA7);
        wait_idle(20);
        check("err_sticky_after_ld", 64'(err_illegal), 64'd1);

        // Reset during ACCESS of core 2, then re-serve with core 0 priority
        cmd[2] = 2'b01; adr[2] = 10'h040; wd[2] = 8'h00;
        step();
        check("rst_mid_access_en", 64'(mem_en), 64'd1);
        check("rst_mid_access_grant", 64'(grant_id), 64'd2);
        reset = 1'b1;
        #1;
        check("rst_mid_mem_en", 64'(mem_en), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_ready", 64'(ready_M), 64'd0);
        check("rst_mid_err_cleared", 64'(err_illegal), 64'd0);
        issue(1, 2'b01, 10'h041, 8'h00, 8'h88);
        issue(2, 2'b01, 10'h040, 8'h00, 8'h77);
        repeat (2) step();
        reset = 1'b0;
        wait_idle(30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
